sub_shift_seq: RTL and testbench

SUB_SHIFT_SEQ -- requirements
Module: sub_shift_seq

---
 rtl/aes128Pkg.sv | 72 +++++++
 rtl/subWord.sv | 12 +
 rtl/sub_shift_seq.sv | 102 ++++++++++
 tb/tb_sub_shift_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/aes128Pkg.sv
// Shared AES-128 types plus the SubBytes/ShiftRows helpers used by sub_shift_seq.
// Byte k of FIPS-197 order lives in Matrix bits [127-8k -: 8]; column c is bits [127-32c -: 32].
package aes128Pkg;

    typedef logic [7:0]   Byte;
    typedef logic [31:0]  Word;
    typedef logic [127:0] Matrix;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_shift_state_e;

    // FIPS-197 forward S-box, indexed by the input byte.
    localparam Byte SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic Word get_col(input Matrix m, input logic [1:0] c);
        Word w;
        case (c)
            2'd0:    w = m[127:96];
            2'd1:    w = m[95:64];
            2'd2:    w = m[63:32];
            2'd3:    w = m[31:0];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic Matrix set_col(input Matrix m, input logic [1:0] c, input Word w);
        Matrix res;
        res = m;
        case (c)
            2'd0:    res[127:96] = w;
            2'd1:    res[95:64]  = w;
            2'd2:    res[63:32]  = w;
            2'd3:    res[31:0]   = w;
            default: res = m;
        endcase
        return res;
    endfunction

    // Row r of the output takes its byte from column (c + r) mod 4.
    function automatic Matrix shift_rows(input Matrix m);
        Matrix res;
        res = m;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8*(4*c + r) -: 8] = m[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/subWord.sv
// Four parallel forward S-box lookups on one 32-bit state column.
module subWord
    import aes128Pkg::*;
(
    input  Word col_word,
    output Word sub_word
);

    assign sub_word = {SBOX[col_word[31:24]], SBOX[col_word[23:16]],
                       SBOX[col_word[15:8]],  SBOX[col_word[7:0]]};

endmodule

// File: rtl/sub_shift_seq.sv
// Column-serial SubBytes (+ optional ShiftRows) engine: one column per cycle, 5-edge latency.
// Macro SUBSHIFT_SHIFTROWS_EN: when defined, ShiftRows is applied to Out_DO; otherwise SubBytes only.
module sub_shift_seq
    import aes128Pkg::*;
(
    input  logic  Clk_CI,
    input  logic  Rst_RBI,
    input  Matrix In_DI,
    input  logic  InValid_SI,
    output logic  InReady_SO,
    output Matrix Out_DO,
    output logic  OutValid_SO,
    input  logic  OutReady_SI
);

    sub_shift_state_e state_r;
    logic [1:0]       col_cnt_r;
    Matrix            mat_r;
    Matrix            out_r;
    logic             in_ready_r;
    logic             out_valid_r;

    Word              col_word_s;
    Word              sub_word_s;
    Matrix            sub_mat_s;
    Matrix            done_view_s;

    assign col_word_s = get_col(mat_r, col_cnt_r);

    subWord u_sub_word (
        .col_word (col_word_s),
        .sub_word (sub_word_s)
    );

    assign sub_mat_s = set_col(mat_r, col_cnt_r, sub_word_s);

`ifdef SUBSHIFT_SHIFTROWS_EN
    assign done_view_s = shift_rows(sub_mat_s);
`else
    assign done_view_s = sub_mat_s;
`endif

    // Control FSM, column walk and registered handshake/data outputs.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state_r     <= IDLE;
            col_cnt_r   <= 2'd0;
            mat_r       <= 128'd0;
            out_r       <= 128'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // in_ready_r is low for one IDLE cycle after reset, so no capture happens there.
                    if (in_ready_r && InValid_SI) begin
                        mat_r      <= In_DI;
                        col_cnt_r  <= 2'd0;
                        state_r    <= BUSY;
                        in_ready_r <= 1'b0;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                BUSY: begin
                    mat_r     <= sub_mat_s;
                    col_cnt_r <= col_cnt_r + 2'd1;
                    if (col_cnt_r == 2'd3) begin
                        state_r     <= DONE;
                        out_r       <= done_view_s;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                DONE: begin
                    if (OutReady_SI) begin
                        state_r     <= IDLE;
                        out_r       <= 128'd0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    col_cnt_r   <= 2'd0;
                    mat_r       <= 128'd0;
                    out_r       <= 128'd0;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign InReady_SO  = in_ready_r;
    assign OutValid_SO = out_valid_r;
    assign Out_DO      = out_r;

endmodule

// File: tb/tb_sub_shift_seq.sv
// Scoreboard bench for sub_shift_seq: directed FIPS-197 vectors, back-pressure, reset, streaming.
module tb_sub_shift_seq;

    logic         clk;
    logic         Rst_RBI;
    logic [127:0] In_DI;
    logic         InValid_SI;
    logic         InReady_SO;
    logic [127:0] Out_DO;
    logic         OutValid_SO;
    logic         OutReady_SI;

    localparam logic [127:0] R1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] R2_IN  = 128'ha49c7ff2689f352b6b5bea43026a5049;
`ifdef SUBSHIFT_SHIFTROWS_EN
    localparam logic [127:0] R1_EXP = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] R2_EXP = 128'h49db873b453953897f02d2f177de961a;
`else
    localparam logic [127:0] R1_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] R2_EXP = 128'h49ded28945db96f17f39871a7702533b;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [127:0] exp_q[$];
    int           pop_cyc_q[$];

    sub_shift_seq dut (
        .Clk_CI      (clk),
        .Rst_RBI     (Rst_RBI),
        .In_DI       (In_DI),
        .InValid_SI  (InValid_SI),
        .InReady_SO  (InReady_SO),
        .Out_DO      (Out_DO),
        .OutValid_SO (OutValid_SO),
        .OutReady_SI (OutReady_SI)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented-and-taken output is matched against the oldest expectation.
    always @(negedge clk) begin
        if (Rst_RBI === 1'b1 && OutValid_SO === 1'b1 && OutReady_SI === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", Out_DO);
            end else begin
                check("out_data", Out_DO, exp_q.pop_front());
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (InReady_SO === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout: got InReady_SO=0 expected 1 within 64 cycles");
    endtask

    task automatic issue(input logic [127:0] m, input logic [127:0] e, input bit push);
        wait_ready();
        In_DI      = m;
        InValid_SI = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        InValid_SI = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge clk);
        check("drained", 128'(exp_q.size()), 128'd0);
        #1;
    endtask

    initial begin
        int lat;
        int base;
        Rst_RBI     = 1'b0;
        In_DI       = 128'd0;
        InValid_SI  = 1'b0;
        OutReady_SI = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(InReady_SO), 128'd0);
        check("rst_out_valid", 128'(OutValid_SO), 128'd0);
        check("rst_out_data", Out_DO, 128'd0);
        Rst_RBI = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 128'(InReady_SO), 128'd1);
        OutReady_SI = 1'b1;

        // FIPS-197 round 1 with latency measured from the acceptance edge (counted as edge 1).
        issue(R1_IN, R1_EXP, 1'b1);
        lat = 0;
        for (int i = 1; i < 20; i++) begin
            if (OutValid_SO === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("latency_edges", 128'(lat), 128'd5);
        drain();

        issue({16{8'h00}}, {16{8'h63}}, 1'b1);
        drain();
        issue({16{8'hff}}, {16{8'h16}}, 1'b1);
        drain();

        // Back-pressure: hold DONE for 10 cycles while poking InValid_SI.
        OutReady_SI = 1'b0;
        issue(R2_IN, R2_EXP, 1'b1);
        for (int i = 0; i < 20 && OutValid_SO !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 10; k++) begin
            check("bp_out_data", Out_DO, R2_EXP);
            check("bp_out_valid", 128'(OutValid_SO), 128'd1);
            check("bp_in_ready", 128'(InReady_SO), 128'd0);
            In_DI      = {16{8'haa}};
            InValid_SI = k[0];
            @(posedge clk);
            #1;
        end
        InValid_SI  = 1'b0;
        OutReady_SI = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 128'(OutValid_SO), 128'd0);
        check("bp_release_ready", 128'(InReady_SO), 128'd1);
        drain();

        // Reset while ColCnt=2: the in-flight state must vanish.
        issue({16{8'h01}}, {16{8'h7c}}, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        Rst_RBI = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 128'(InReady_SO), 128'd0);
        Rst_RBI = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 128'(OutValid_SO), 128'd0);
        check("midrst_out_data", Out_DO, 128'd0);
        check("midrst_in_ready_after", 128'(InReady_SO), 128'd1);
        repeat (8) @(posedge clk);
        #1;
        issue(R1_IN, R1_EXP, 1'b1);
        drain();

        // Streaming: InValid_SI and OutReady_SI held high across three states.
        base = pop_cyc_q.size();
        for (int j = 0; j < 3; j++) begin
            wait_ready();
            case (j)
                0:       begin In_DI = R2_IN;         exp_q.push_back(R2_EXP);        end
                1:       begin In_DI = {16{8'h53}};  exp_q.push_back({16{8'hed}});  end
                default: begin In_DI = R1_IN;         exp_q.push_back(R1_EXP);        end
            endcase
            InValid_SI = 1'b1;
            @(posedge clk);
            #1;
        end
        InValid_SI = 1'b0;
        drain();
        check("stream_count", 128'(pop_cyc_q.size() - base), 128'd3);
        if (pop_cyc_q.size() - base == 3) begin
            check("stream_gap0", 128'(pop_cyc_q[base + 1] - pop_cyc_q[base]), 128'd6);
            check("stream_gap1", 128'(pop_cyc_q[base + 2] - pop_cyc_q[base + 1]), 128'd6);
        end

        repeat (10) @(posedge clk);
        check("final_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
